// File: rtl/uart_pkg.sv
// Shared UART framing constants and framer state encoding.
// The RX parser imports the same markers so both ends agree on the framing.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hAA;
  localparam logic [7:0] TYPE_RGB = 8'h43;
  localparam logic [7:0] TYPE_LED = 8'h4C;

  localparam int RGB_FRAME_LEN = 6;
  localparam int LED_FRAME_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XMIT,
    ST_DONE
  } framer_state_t;

endpackage

// File: rtl/status_tx_framer_if.sv
// Request/serial-output bundle between the user-interface logic and the status framer.
interface status_tx_framer_if;
  logic        send_rgb;
  logic [23:0] rgb_msg;
  logic        send_led;
  logic [7:0]  led_msg;
  logic        tx_line;
  logic        busy;
  logic        frame_done;

  modport master (
    output send_rgb, rgb_msg, send_led, led_msg,
    input  tx_line, busy, frame_done
  );

  modport slave (
    input  send_rgb, rgb_msg, send_led, led_msg,
    output tx_line, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] baud;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          active;

  assign byte_done = active && (bit_cnt == 4'd9) && (baud == BAUD_LAST);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        shreg   <= {1'b1, data, 1'b0};
        tx      <= 1'b0;
        baud    <= '0;
        bit_cnt <= '0;
      end
    end else if (baud == BAUD_LAST) begin
      baud <= '0;
      if (bit_cnt == 4'd9) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        tx      <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {1'b1, shreg[9:1]};
        tx      <= shreg[1];
      end
    end else begin
      baud <= baud + BW'(1);
    end
  end

endmodule

// File: rtl/status_tx_framer.sv
// Status transmit framer: queues one RGB and one LED report and sends them as framed 8N1 bytes.
//   state | meaning
//   IDLE  | no frame; pick pending RGB first, then LED
//   LOAD  | present current byte to the serializer and start it
//   XMIT  | serializer running the current byte
//   DONE  | frame complete, frame_done pulses
module status_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              sys_clk,
  input  logic              rst,
  status_tx_framer_if.slave bus
);

  framer_state_t state, state_nxt;

  logic        pend_rgb, pend_led;
  logic [23:0] pend_rgb_data;
  logic [7:0]  pend_led_data;
  logic [23:0] shadow;
  logic        frame_rgb;
  logic [2:0]  idx, last_idx;
  logic        take_rgb, take_led, idx_inc, byte_start, byte_done;
  logic [7:0]  cur_byte, chk;

  assign last_idx = frame_rgb ? 3'(RGB_FRAME_LEN - 1) : 3'(LED_FRAME_LEN - 1);
  assign chk = frame_rgb ? (TYPE_RGB ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0])
                         : (TYPE_LED ^ shadow[7:0]);

  always_comb begin
    state_nxt  = state;
    take_rgb   = 1'b0;
    take_led   = 1'b0;
    idx_inc    = 1'b0;
    byte_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_rgb) begin
          take_rgb  = 1'b1;
          state_nxt = ST_LOAD;
        end else if (pend_led) begin
          take_led  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        byte_start = 1'b1;
        state_nxt  = ST_XMIT;
      end
      ST_XMIT: begin
        if (byte_done) begin
          if (idx == last_idx) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = SOF_BYTE;
    case (idx)
      3'd0:    cur_byte = SOF_BYTE;
      3'd1:    cur_byte = frame_rgb ? TYPE_RGB : TYPE_LED;
      3'd2:    cur_byte = frame_rgb ? shadow[23:16] : shadow[7:0];
      3'd3:    cur_byte = frame_rgb ? shadow[15:8] : chk;
      3'd4:    cur_byte = shadow[7:0];
      3'd5:    cur_byte = chk;
      default: cur_byte = SOF_BYTE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pend_rgb      <= 1'b0;
      pend_led      <= 1'b0;
      pend_rgb_data <= '0;
      pend_led_data <= '0;
      shadow        <= '0;
      frame_rgb     <= 1'b0;
      idx           <= '0;
    end else begin
      state <= state_nxt;
      if (take_rgb) begin
        shadow    <= pend_rgb_data;
        frame_rgb <= 1'b1;
        idx       <= '0;
        pend_rgb  <= 1'b0;
      end
      if (take_led) begin
        shadow    <= {16'h0000, pend_led_data};
        frame_rgb <= 1'b0;
        idx       <= '0;
        pend_led  <= 1'b0;
      end
      if (idx_inc) idx <= idx + 3'd1;
      // A request landing on the same cycle as its frame start re-arms the slot.
      if (bus.send_rgb) begin
        pend_rgb      <= 1'b1;
        pend_rgb_data <= bus.rgb_msg;
      end
      if (bus.send_led) begin
        pend_led      <= 1'b1;
        pend_led_data <= bus.led_msg;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (byte_start),
    .data      (cur_byte),
    .tx        (bus.tx_line),
    .byte_done (byte_done)
  );

  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = (state == ST_DONE);

endmodule
